// File: rtl/z88_mem_pkg.sv
// z88_mem_pkg: memory-side types and widths shared by Blink, the screen renderer and the SRAM arbiter.
package z88_mem_pkg;
  localparam int MEM_AW = 20;
  localparam int MEM_DW = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_VID} owner_e;
endpackage

// File: rtl/z88_sram_arbiter.sv
// z88_sram_arbiter: CPU-priority sharing of one async SRAM between the Z80/Blink port and LCD fetch.
module z88_sram_arbiter
  import z88_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int ACC_CYCLES = 2,
  parameter int STARVE     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic [DW-1:0] vid_do,
  output logic          vid_ack,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);
  localparam int CW = $clog2(ACC_CYCLES);
  localparam int VW = $clog2(STARVE + 1);
  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vid_wait_q, vid_wait_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] di_q, di_d, cdo_q, cdo_d, vdo_q, vdo_d;
  logic          wr_q, wr_d, ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic          cack_q, cack_d, vack_q, vack_d, vid_win, vid_busy;
  assign vid_win  = vid_req && (!cpu_req || vid_wait_q == VW'(STARVE));
  assign vid_busy = state_q != IDLE && own_q == OWN_VID;
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    di_d       = di_q;
    wr_d       = wr_q;
    cdo_d      = cdo_q;
    vdo_d      = vdo_q;
    ce_d       = 1'b1;
    oe_d       = 1'b1;
    we_d       = 1'b1;
    cack_d     = 1'b0;
    vack_d     = 1'b0;
    vid_wait_d = vid_wait_q;
    unique case (state_q)
      IDLE: if (cpu_req || vid_req) begin
        state_d = ACCESS;
        own_d   = vid_win ? OWN_VID : OWN_CPU;
        wr_d    = !vid_win && cpu_we;
        a_d     = vid_win ? vid_a : cpu_a;
        di_d    = (!vid_win && cpu_we) ? cpu_di : di_q;
        cnt_d   = CW'(ACC_CYCLES - 1);
        ce_d    = 1'b0;
        oe_d    = !vid_win && cpu_we;
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = DONE;
        cack_d  = own_q == OWN_CPU;
        vack_d  = own_q == OWN_VID;
        cdo_d   = (own_q == OWN_CPU && !wr_q) ? sram_do : cdo_q;
        vdo_d   = (own_q == OWN_VID) ? sram_do : vdo_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
        ce_d  = 1'b0;
        oe_d  = wr_q;
        we_d  = !wr_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Waiting counts only while video is pending and not already being served
    if (state_q == IDLE && vid_win) vid_wait_d = '0;
    else if (vid_req && !vid_busy && vid_wait_q != VW'(STARVE)) vid_wait_d = vid_wait_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      own_q      <= OWN_CPU;
      cnt_q      <= '0;
      vid_wait_q <= '0;
      a_q        <= '0;
      di_q       <= '0;
      wr_q       <= 1'b0;
      cdo_q      <= '0;
      vdo_q      <= '0;
      ce_q       <= 1'b1;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
      cack_q     <= 1'b0;
      vack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      cnt_q      <= cnt_d;
      vid_wait_q <= vid_wait_d;
      a_q        <= a_d;
      di_q       <= di_d;
      wr_q       <= wr_d;
      cdo_q      <= cdo_d;
      vdo_q      <= vdo_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      cack_q     <= cack_d;
      vack_q     <= vack_d;
    end
  end
  assign sram_a    = a_q;
  assign sram_di   = di_q;
  assign sram_ce_n = ce_q;
  assign sram_oe_n = oe_q;
  assign sram_we_n = we_q;
  assign cpu_do    = cdo_q;
  assign vid_do    = vdo_q;
  assign cpu_ack   = cack_q;
  assign vid_ack   = vack_q;
endmodule

// File: tb/tb_z88_sram_arbiter.sv
// tb_z88_sram_arbiter: directed checks of grant order, strobe timing, starvation and reset abort.
module tb_z88_sram_arbiter;
  import z88_mem_pkg::*;
  logic        clk = 0, reset_n = 0;
  logic        cpu_req = 0, cpu_we = 0, vid_req = 0;
  logic [19:0] cpu_a = 0, vid_a = 0, sram_a;
  logic [7:0]  cpu_di = 0, cpu_do, vid_do, sram_di, sram_do;
  logic        cpu_ack, vid_ack, sram_ce_n, sram_oe_n, sram_we_n;
  int checks = 0, failures = 0, cyc = 0;
  int n_ce, n_oe, n_we, n_cack, n_vack, ce_first, ce_last, we_first, we_last, vw_max;
  logic [19:0] a_at_ce;
  logic [7:0]  di_at_ce;
  int ack_cyc, t0, t1, t2, cpu_acks;
  z88_sram_arbiter #(.AW(20), .DW(8), .ACC_CYCLES(2), .STARVE(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_a(vid_a), .vid_do(vid_do), .vid_ack(vid_ack),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));
  always #5 clk = ~clk;
  // SRAM contents as a fixed function of the address; expected reads are precomputed constants
  assign sram_do = sram_a[7:0] ^ sram_a[15:8] ^ 8'h83;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!sram_ce_n) begin
      if (ce_first < 0) begin ce_first = cyc; a_at_ce = sram_a; di_at_ce = sram_di; end
      ce_last = cyc; n_ce++;
    end
    if (!sram_oe_n) n_oe++;
    if (!sram_we_n) begin if (we_first < 0) we_first = cyc; we_last = cyc; n_we++; end
    if (cpu_ack) n_cack++;
    if (vid_ack) n_vack++;
    if (int'(dut.vid_wait_q) > vw_max) vw_max = int'(dut.vid_wait_q);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_ce = 0; n_oe = 0; n_we = 0; n_cack = 0; n_vack = 0;
    ce_first = -1; ce_last = -1; we_first = -1; we_last = -1; vw_max = 0;
  endtask
  task automatic cpu_op(input logic we, input logic [19:0] a, input logic [7:0] di, output int ac);
    bit seen = 0;
    @(negedge clk);
    cpu_we = we; cpu_a = a; cpu_di = di; cpu_req = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    cpu_req = 0;
    ac = cyc;
    if (!seen) chk("cpu_ack_timeout", 0, 1);
  endtask
  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_acks", {cpu_ack, vid_ack}, 0);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_data", {cpu_do, vid_do, sram_di}, 0);
    reset_n = 1;
    @(negedge clk);
    clr();
    cpu_op(0, 20'h0_1234, 8'h00, ack_cyc);
    repeat (3) @(negedge clk);
    chk("rd_ce_cycles", n_ce, 2);
    chk("rd_oe_cycles", n_oe, 2);
    chk("rd_we_cycles", n_we, 0);
    chk("rd_ack_pulses", n_cack, 1);
    chk("rd_ack_latency", ack_cyc - ce_first, 2);
    chk("rd_cpu_do", cpu_do, 8'hA5);
    chk("rd_sram_a", a_at_ce, 20'h0_1234);
    clr();
    cpu_op(1, 20'h7_FFFF, 8'h3C, ack_cyc);
    repeat (3) @(negedge clk);
    chk("wr_a_at_grant", a_at_ce, 20'h7_FFFF);
    chk("wr_di_at_grant", di_at_ce, 8'h3C);
    chk("wr_ce_cycles", n_ce, 2);
    chk("wr_we_cycles", n_we, 1);
    chk("wr_we_delay", we_first - ce_first, 1);
    chk("wr_we_ce_rise", we_last, ce_last);
    chk("wr_oe_cycles", n_oe, 0);
    chk("wr_ack_pulses", n_cack, 1);
    chk("wr_di_held", sram_di, 8'h3C);
    chk("wr_cpu_do_kept", cpu_do, 8'hA5);
    clr();
    chk("sim_wait0", dut.vid_wait_q, 0);
    t0 = -1; t1 = -1;
    @(negedge clk);
    cpu_we = 0; cpu_a = 20'h0_00AA; vid_a = 20'h0_5600; cpu_req = 1; vid_req = 1;
    for (int i = 0; i < 30 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      if (cpu_ack) begin cpu_req = 0; t0 = cyc; end
      if (vid_ack) begin vid_req = 0; t1 = cyc; end
    end
    if (t0 < 0 || t1 < 0) chk("sim_timeout", 0, 1);
    chk("sim_cpu_first", t0 >= 0 && t0 < t1, 1);
    chk("sim_vid_gap", t1 - t0, 4);
    chk("sim_cpu_do", cpu_do, 8'h29);
    chk("sim_vid_do", vid_do, 8'hD5);
    repeat (2) @(negedge clk);
    clr();
    t0 = -1; t1 = -1; cpu_acks = 0;
    @(negedge clk);
    cpu_we = 0; cpu_a = 20'h0_0100; vid_a = 20'h0_0F00; cpu_req = 1; vid_req = 1;
    for (int i = 0; i < 40 && cpu_req; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cpu_acks++;
        if (t0 < 0) t0 = cyc;
        cpu_a = cpu_a + 1;
        if (t1 >= 0) cpu_req = 0;
      end
      if (vid_ack) begin
        vid_req = 0; t1 = cyc; t2 = cpu_acks;
        chk("stv_wait_cleared", dut.vid_wait_q, 0);
      end
    end
    if (t1 < 0 || cpu_req) begin chk("stv_timeout", 0, 1); cpu_req = 0; vid_req = 0; end
    chk("stv_wait_peak", vw_max, 4);
    chk("stv_cpu_before_vid", t2, 1);
    chk("stv_vid_gap", t1 - t0, 4);
    chk("stv_vid_do", vid_do, 8'h8C);
    repeat (2) @(negedge clk);
    cpu_op(0, 20'h0_0010, 8'h00, t0);
    cpu_op(0, 20'h0_0011, 8'h00, t1);
    cpu_op(0, 20'h0_0012, 8'h00, t2);
    chk("b2b_period1", t1 - t0, 4);
    chk("b2b_period2", t2 - t1, 4);
    chk("b2b_cpu_do", cpu_do, 8'h91);
    repeat (2) @(negedge clk);
    clr();
    cpu_op(0, 20'h0_0020, 8'h00, t0);
    cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 0;
    repeat (8) @(negedge clk);
    chk("hold_extra_access", n_cack, 2);
    clr();
    @(negedge clk);
    cpu_we = 0; cpu_a = 20'h0_0030; cpu_req = 1; vid_req = 1;
    @(negedge clk);
    chk("rst_mid_ce_low", sram_ce_n, 0);
    chk("rst_mid_wait_pre", dut.vid_wait_q, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_mid_ack", cpu_ack, 0);
    chk("rst_mid_wait", dut.vid_wait_q, 0);
    cpu_req = 0; vid_req = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ack", n_cack, 0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_mid_cpu_do", cpu_do, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z88_sram_arbiter.md
# z88_sram_arbiter

- Shares one external asynchronous SRAM between two requesters:
  - the Z80/Blink memory port (read/write, covering internal RAM and ROM images);
  - the LCD fetch port (read-only) of the screen renderer.
- Sits between Blink's memory decode and the board SRAM pins.
- Each granted access is sequenced with fixed strobe timing.
- The CPU has priority; a starvation counter bounds video latency.

## Interface
Parameters:
- AW, 20, SRAM address width
- DW, 8, data width
- ACC_CYCLES, 2, cycles strobes stay active per access (≥2)
- STARVE, 8, consecutive lost arbitration cycles after which video wins (≥1)

Ports:
- clk  in  1  master clock; all logic rises on clk
- reset_n  in  1  reset; asynchronous assert, active-low, synchronous deassert by the system
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_a  in  AW  CPU address
- cpu_di  in  DW  CPU write data
- cpu_do  out  DW  CPU read data, valid from cpu_ack, held until next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video read request, level, held until vid_ack
- vid_a  in  AW  video address
- vid_do  out  DW  video read data, valid from vid_ack, held
- vid_ack  out  1  one-cycle completion pulse
- sram_a  out  AW  SRAM address, registered
- sram_di  out  DW  SRAM write data, registered
- sram_do  in  DW  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, registered, active-low

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: all strobes high. At an edge with a pending request, choose the owner, register sram_a (and sram_di for writes), load the cycle counter, and go to ACCESS.
- Arbitration:
  - CPU wins by default.
  - Video wins if only vid_req is pending.
  - Video also wins if both are pending and vid_wait == STARVE.
- vid_wait counter:
  - increments (saturating at STARVE) on each clk where vid_req=1 and video is not granted;
  - clears when video is granted.
- ACCESS, read: ce_n=0 and oe_n=0 for ACC_CYCLES cycles. At the last edge, capture sram_do into the owner's data register, pulse the owner's ack, and go to DONE.
- ACCESS, write (CPU only): ce_n=0 for ACC_CYCLES cycles; we_n=0 for all but the first of them; oe_n stays high. At the last edge, pulse cpu_ack and go to DONE.
- DONE: one turnaround cycle, all strobes high, ack high. Then go to IDLE.
- sram_a and sram_di hold their values until the next grant.
- No preemption: a granted access always completes.
- Reset values: state IDLE; sram_ce_n = sram_oe_n = sram_we_n = 1; acks 0; sram_a, sram_di, cpu_do, vid_do = 0; vid_wait = 0.
- Reset mid-access: strobes go high asynchronously. The access is abandoned and no ack is issued.

## Timing
- A request sampled at edge T:
  - strobes are low for cycles T..T+ACC_CYCLES-1;
  - the ack is high during cycle T+ACC_CYCLES (the DONE cycle);
  - the earliest next grant is at edge T+ACC_CYCLES+2.
- Back-to-back period: ACC_CYCLES+2 cycles.
- A requester must drop req by the edge ending its ack cycle. A req still high at the next IDLE edge is a new request.
- Write setup: address and data are stable one cycle before we_n falls. we_n and ce_n rise on the same edge; data is held through DONE.
- Worst-case video wait with continuous CPU traffic: about STARVE cycles plus one in-flight access.

## Structure
- Package z88_mem_pkg holds:
  - the state encoding (IDLE/ACCESS/DONE);
  - the owner encoding (OWN_CPU/OWN_VID);
  - AW/DW defaults shared with Blink and the screen renderer.
- Single module. The FSM, cycle counter and starvation counter stay inline; no sub-module is warranted.

## Test plan
- **Reset:** assert reset_n=0 mid-ACCESS of a CPU read → same cycle, strobes go to 1, cpu_ack stays 0, vid_wait=0; after release, state is IDLE.
- **CPU read:** cpu_req with cpu_a=0x0_1234, sram_do=0xA5, ACC_CYCLES=2 →
  - ce_n/oe_n low for exactly 2 cycles;
  - cpu_ack pulses 1 cycle;
  - cpu_do=0xA5;
  - we_n never low.
- **CPU write:** cpu_a=0x7_FFFF, cpu_di=0x3C →
  - sram_a/sram_di valid at grant;
  - we_n low 1 cycle (ACC_CYCLES=2), starting one cycle after ce_n falls;
  - oe_n stays 1;
  - cpu_ack pulses once.
- **Simultaneous requests:** cpu_req and vid_req at the same edge, vid_wait=0 → CPU is granted first. Video is granted at the next IDLE edge (T+4) and vid_do gets its data.
- **Starvation:** STARVE=4, cpu_req held continuously with new addresses, vid_req held → video is granted once vid_wait reaches 4, and vid_wait is 0 after the grant.
- **Back-to-back CPU and req hold:**
  - CPU reads issued back-to-back → one access every 4 cycles.
  - If the CPU keeps cpu_req high one extra cycle past its ack cycle → a second access starts (documented requester error).
